bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 108 ++++++++++
 tb/tb_bit_serializer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial shifter with a one-word holding register and a frame counter
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic [15:0]      frames_sent
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic [15:0]      frames_q, frames_d;
    logic [WIDTH-1:0] word;
    logic             load, accept, last;

    assign din_ready   = !pend_valid_q;
    assign busy        = (state_q == SHIFT) || pend_valid_q;
    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frames_sent = frames_q;

    // Next state: load a new word (from din or pending) at idle or on the last bit, else keep shifting
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        frames_d     = frames_q;
        word         = din;
        load         = 1'b0;
        accept       = din_valid && !pend_valid_q;
        last         = (state_q == SHIFT) && (cnt_q == LAST);
        if (state_q == IDLE) begin
            load = accept;
        end else if (last) begin
            frames_d = frames_q + 16'd1;
            if (pend_valid_q) begin
                load         = 1'b1;
                word         = pend_q;
                pend_valid_d = 1'b0;
            end else begin
                load = accept;
            end
        end else if (accept) begin
            pend_d       = din;
            pend_valid_d = 1'b1;
        end
        if (load) begin
            state_d      = SHIFT;
            cnt_d        = '0;
            sout_d       = MSB_FIRST ? word[WIDTH-1] : word[0];
            shreg_d      = MSB_FIRST ? word << 1 : word >> 1;
            sout_valid_d = 1'b1;
        end else if (last) begin
            state_d      = IDLE;
            cnt_d        = '0;
            shreg_d      = '0;
            sout_d       = IDLE_BIT;
            sout_valid_d = 1'b0;
        end else if (state_q == SHIFT) begin
            cnt_d   = cnt_q + 1'b1;
            sout_d  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
            shreg_d = MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
        end
    end

    // State registers; reset discards the word in flight and any pending word
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            sout_q       <= IDLE_BIT;
            sout_valid_q <= 1'b0;
            frames_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            frames_q     <= frames_d;
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed checks of bit_serializer in LSB-first and MSB-first configurations
module tb_bit_serializer;
    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  din = '0, din1 = '0;
    logic        din_valid = 1'b0, din_valid1 = 1'b0;
    logic        din_ready, sout, sout_valid, busy;
    logic        din_ready1, sout1, sout_valid1, busy1;
    logic [15:0] frames_sent, frames_sent1;
    logic [2:0]  hist;
    int          total = 0;
    int          bad = 0;
    int          frames_exp = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .areset(areset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sout(sout), .sout_valid(sout_valid), .busy(busy), .frames_sent(frames_sent));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut1 (
        .clk(clk), .areset(areset), .din(din1), .din_valid(din_valid1), .din_ready(din_ready1),
        .sout(sout1), .sout_valid(sout_valid1), .busy(busy1), .frames_sent(frames_sent1));

    always #5 clk = ~clk;

    // Downstream 1-0-1 pattern observer on the MSB-first stream
    always @(posedge clk or posedge areset)
        if (areset) hist <= '0;
        else if (sout_valid1) hist <= {hist[1:0], sout1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send0(input logic [7:0] w);
        din = w;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bit%0d_of_%0h", i, w), {30'd0, sout_valid, sout}, {30'd0, 1'b1, w[i]});
            @(negedge clk);
        end
        frames_exp++;
        chk("idle_after_word", {30'd0, sout_valid, sout}, 32'd0);
        chk("frames_after_word", frames_sent, frames_exp);
    endtask

    initial begin
        logic [15:0] s2;
        logic [7:0]  w [3];
        logic [7:0]  e;
        logic        acc;
        int          k;
        repeat (2) @(negedge clk);
        chk("rst_ready", din_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sout", {sout_valid, sout}, 0);
        chk("rst_frames", frames_sent, 0);
        chk("rst_idle_bit1", {sout_valid1, sout1}, 1);
        areset = 1'b0;

        din = 8'hA5;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        chk("busy_shift", busy, 1);
        for (int i = 0; i < 8; i++) begin
            e = 8'hA5;
            chk($sformatf("a5_bit%0d", i), {sout_valid, sout}, {1'b1, e[i]});
            @(negedge clk);
        end
        frames_exp = 1;
        chk("a5_idle", {sout_valid, sout}, 0);
        chk("a5_frames", frames_sent, frames_exp);

        s2 = 16'h3CA5;
        din = 8'hA5;
        din_valid = 1'b1;
        @(negedge clk);
        din = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            if (i == 1) din_valid = 1'b0;
            chk($sformatf("b2b_bit%0d", i), {sout_valid, sout}, {1'b1, s2[i]});
            @(negedge clk);
        end
        frames_exp += 2;
        chk("b2b_idle", sout_valid, 0);
        chk("b2b_frames", frames_sent, frames_exp);

        w[0] = 8'h6B; w[1] = 8'hD2; w[2] = 8'h1E;
        din = w[0];
        din_valid = 1'b1;
        @(negedge clk);
        k = 1;
        din = w[1];
        for (int i = 0; i < 24; i++) begin
            e = w[i / 8];
            chk($sformatf("bp_bit%0d", i), {sout_valid, sout}, {1'b1, e[i % 8]});
            chk($sformatf("bp_ready%0d", i), din_ready, (i % 8 == 0) || (i >= 16));
            acc = din_valid && din_ready;
            @(negedge clk);
            if (acc) begin
                k++;
                if (k < 3) din = w[k];
                else din_valid = 1'b0;
            end
        end
        frames_exp += 3;
        chk("bp_accepted", k, 3);
        chk("bp_idle", {busy, sout_valid}, 0);
        chk("bp_frames", frames_sent, frames_exp);

        din = 8'hFF;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_bit4", {sout_valid, sout}, 2'b11);
        areset = 1'b1;
        #1;
        chk("rst_mid_valid", {sout_valid, sout}, 0);
        chk("rst_mid_frames", frames_sent, 0);
        chk("rst_mid_busy", {busy, din_ready}, 2'b01);
        @(negedge clk);
        areset = 1'b0;
        frames_exp = 0;
        send0(8'h96);

        din1 = 8'h05;
        din_valid1 = 1'b1;
        @(negedge clk);
        din_valid1 = 1'b0;
        e = 8'h05;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("msb_bit%0d", i), {sout_valid1, sout1}, {1'b1, e[7 - i]});
            if (i == 7) chk("det_early", hist == 3'b101, 0);
            @(negedge clk);
        end
        chk("det_hit", hist == 3'b101, 1);
        chk("msb_idle_bit", {sout_valid1, sout1}, 1);
        chk("msb_frames", frames_sent1, 1);

        force dut0.frames_q = 16'hFFFF;
        @(negedge clk);
        release dut0.frames_q;
        @(negedge clk);
        chk("wrap_pre", frames_sent, 16'hFFFF);
        frames_exp = -1;
        send0(8'h5A);
        chk("wrap_zero", frames_sent, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
